// File: rtl/zwait_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : zwait_ctrl_if
//  Purpose  : Z80-side bus bundle between the I/O decoder / bus mux and the
//             wait controller.
//  Signals  : iorq_n   - Z80 /IORQ, synchronized to fclk
//             req_glu  - one-cycle pulse, gluclock data port access
//             req_com  - one-cycle pulse, COM port access
//             req_rnw  - direction of the pulsed access, 1 = read
//             addr_we  - one-cycle pulse, write to gluclock address port
//             zd_in    - Z80 data bus, write direction
//             wait_n   - Z80 /WAIT, 0 = stall
//             zd_out   - read data to the Z80 bus mux
//             zd_oe    - 1 = drive zd_out onto the Z80 bus
//  Modports : master = decoder / bus side, slave = wait controller
//  Revision : 1.0 - initial release
// ============================================================================
interface zwait_ctrl_if;
   logic       iorq_n;
   logic       req_glu;
   logic       req_com;
   logic       req_rnw;
   logic       addr_we;
   logic [7:0] zd_in;
   logic       wait_n;
   logic [7:0] zd_out;
   logic       zd_oe;

   modport master (
      output iorq_n, req_glu, req_com, req_rnw, addr_we, zd_in,
      input  wait_n, zd_out, zd_oe
   );

   modport slave (
      input  iorq_n, req_glu, req_com, req_rnw, addr_we, zd_in,
      output wait_n, zd_out, zd_oe
   );
endinterface
`default_nettype wire

// File: rtl/zwait_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : zwait_ctrl
//  Purpose  : Stalls Z80 I/O accesses serviced by the AVR (gluclock data port,
//             COM port) by holding /WAIT low, hands the latched write data and
//             direction to the SPI slave, and returns AVR read data to the Z80
//             once the slave pulses wait_end. A cycle counter forces release
//             if the AVR never answers.
//  Ports    : fclk, rst_n    - clock, asynchronous active-low reset
//             zbus (slave)   - Z80-side bus bundle (see zwait_ctrl_if)
//             wait_read      - AVR read data, valid with wait_end
//             wait_end       - one-cycle pulse, AVR finished the transaction
//             wait_write     - latched Z80 write data
//             wait_rnw       - latched direction, 1 = read
//             gluclock_addr  - gluclock register address
//             status_out     - [0] pending, [1] source (1 = com), [2] rnw
//             timeout_flag   - sticky, set on forced release
//  Revision : 1.0 - initial release
// ============================================================================
module zwait_ctrl #(
   parameter logic [23:0] TIMEOUT   = 24'd7_000_000,
   parameter logic [7:0]  IDLE_DATA = 8'hFF
) (
   input  logic        fclk,
   input  logic        rst_n,
   zwait_ctrl_if.slave zbus,
   input  logic [7:0]  wait_read,
   input  logic        wait_end,
   output logic [7:0]  wait_write,
   output logic        wait_rnw,
   output logic [7:0]  gluclock_addr,
   output logic [2:0]  status_out,
   output logic        timeout_flag
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   localparam logic [23:0] c_timeout_last = TIMEOUT - 24'd1;
   localparam logic [23:0] c_count_max    = 24'hFF_FFFF;

   state_t      r_state,      w_state_nxt;
   logic        r_wait_n,     w_wait_n_nxt;
   logic [7:0]  r_zd_out,     w_zd_out_nxt;
   logic        r_zd_oe,      w_zd_oe_nxt;
   logic [7:0]  r_wait_write, w_wait_write_nxt;
   logic        r_wait_rnw,   w_wait_rnw_nxt;
   logic [7:0]  r_gaddr,      w_gaddr_nxt;
   logic [2:0]  r_status,     w_status_nxt;
   logic        r_tflag,      w_tflag_nxt;
   logic [23:0] r_count,      w_count_nxt;
   logic        w_timeout;

   // A zero TIMEOUT disables forced release entirely.
   assign w_timeout = (TIMEOUT != 24'd0) && (r_count == c_timeout_last);

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_wait_n     <= 1'b1;
         r_zd_out     <= 8'hFF;
         r_zd_oe      <= 1'b0;
         r_wait_write <= 8'h00;
         r_wait_rnw   <= 1'b1;
         r_gaddr      <= 8'h00;
         r_status     <= 3'b000;
         r_tflag      <= 1'b0;
         r_count      <= 24'd0;
      end else begin
         r_state      <= w_state_nxt;
         r_wait_n     <= w_wait_n_nxt;
         r_zd_out     <= w_zd_out_nxt;
         r_zd_oe      <= w_zd_oe_nxt;
         r_wait_write <= w_wait_write_nxt;
         r_wait_rnw   <= w_wait_rnw_nxt;
         r_gaddr      <= w_gaddr_nxt;
         r_status     <= w_status_nxt;
         r_tflag      <= w_tflag_nxt;
         r_count      <= w_count_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_wait_n_nxt     = r_wait_n;
      w_zd_out_nxt     = r_zd_out;
      w_zd_oe_nxt      = r_zd_oe;
      w_wait_write_nxt = r_wait_write;
      w_wait_rnw_nxt   = r_wait_rnw;
      w_status_nxt     = r_status;
      w_tflag_nxt      = r_tflag;
      w_count_nxt      = r_count;

      // The address port never stalls and is honoured in every state.
      w_gaddr_nxt = zbus.addr_we ? zbus.zd_in : r_gaddr;

      case (r_state)
         S_IDLE: begin
            if (zbus.req_glu || zbus.req_com) begin
               w_state_nxt      = S_WAIT;
               w_wait_n_nxt     = 1'b0;
               w_wait_rnw_nxt   = zbus.req_rnw;
               // Captured unconditionally; the slave ignores it on reads.
               w_wait_write_nxt = zbus.zd_in;
               // Source bit is 0 whenever glu is present: glu wins a tie.
               w_status_nxt     = {zbus.req_rnw, ~zbus.req_glu, 1'b1};
               w_count_nxt      = 24'd0;
               w_tflag_nxt      = 1'b0;
            end
         end

         S_WAIT: begin
            if (r_count != c_count_max) begin
               w_count_nxt = r_count + 24'd1;
            end
            // wait_end has priority, so a coincident timeout is a normal finish.
            if (wait_end) begin
               w_state_nxt     = S_HOLD;
               w_zd_out_nxt    = r_wait_rnw ? wait_read : 8'hFF;
               w_zd_oe_nxt     = r_wait_rnw;
               w_wait_n_nxt    = 1'b1;
               w_status_nxt[0] = 1'b0;
            end else if (w_timeout) begin
               w_state_nxt     = S_HOLD;
               w_zd_out_nxt    = IDLE_DATA;
               w_zd_oe_nxt     = r_wait_rnw;
               w_wait_n_nxt    = 1'b1;
               w_tflag_nxt     = 1'b1;
               w_status_nxt[0] = 1'b0;
            end
         end

         S_HOLD: begin
            // Keep the bus driven until the Z80 ends its I/O cycle.
            if (zbus.iorq_n) begin
               w_state_nxt = S_IDLE;
               w_zd_oe_nxt = 1'b0;
            end
         end

         default: begin
            w_state_nxt  = S_IDLE;
            w_wait_n_nxt = 1'b1;
            w_zd_oe_nxt  = 1'b0;
         end
      endcase
   end

   assign zbus.wait_n   = r_wait_n;
   assign zbus.zd_out   = r_zd_out;
   assign zbus.zd_oe    = r_zd_oe;
   assign wait_write    = r_wait_write;
   assign wait_rnw      = r_wait_rnw;
   assign gluclock_addr = r_gaddr;
   assign status_out    = r_status;
   assign timeout_flag  = r_tflag;

endmodule
`default_nettype wire

// File: tb/tb_zwait_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_zwait_ctrl
//  Purpose  : Self-checking bench for zwait_ctrl. Two instances share all
//             stimulus: dut_s with a 16-cycle timeout and dut_l with the
//             default (effectively infinite here) timeout for long stalls.
//             Expected release results are queued at request time and
//             compared when /WAIT is released.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_zwait_ctrl;

   logic       fclk;
   logic       rst_n;
   logic       iorq_n, req_glu, req_com, req_rnw, addr_we, wait_end;
   logic [7:0] zd_in, wait_read;

   logic [7:0] wait_write_s, gaddr_s, wait_write_l, gaddr_l;
   logic       wait_rnw_s, tflag_s, wait_rnw_l, tflag_l;
   logic [2:0] status_s, status_l;

   typedef struct packed {
      logic [7:0] zd_out;
      logic       zd_oe;
      logic       tflag;
   } exp_t;

   exp_t sb_q[$];
   exp_t e;
   int   n_checks = 0;
   int   n_errors = 0;

   zwait_ctrl_if zs ();
   zwait_ctrl_if zl ();

   assign zs.iorq_n = iorq_n;  assign zl.iorq_n = iorq_n;
   assign zs.req_glu = req_glu; assign zl.req_glu = req_glu;
   assign zs.req_com = req_com; assign zl.req_com = req_com;
   assign zs.req_rnw = req_rnw; assign zl.req_rnw = req_rnw;
   assign zs.addr_we = addr_we; assign zl.addr_we = addr_we;
   assign zs.zd_in = zd_in;     assign zl.zd_in = zd_in;

   zwait_ctrl #(.TIMEOUT(24'd16), .IDLE_DATA(8'hFF)) dut_s (
      .fclk(fclk), .rst_n(rst_n), .zbus(zs),
      .wait_read(wait_read), .wait_end(wait_end),
      .wait_write(wait_write_s), .wait_rnw(wait_rnw_s),
      .gluclock_addr(gaddr_s), .status_out(status_s), .timeout_flag(tflag_s)
   );

   zwait_ctrl dut_l (
      .fclk(fclk), .rst_n(rst_n), .zbus(zl),
      .wait_read(wait_read), .wait_end(wait_end),
      .wait_write(wait_write_l), .wait_rnw(wait_rnw_l),
      .gluclock_addr(gaddr_l), .status_out(status_l), .timeout_flag(tflag_l)
   );

   initial fclk = 1'b0;
   always #5 fclk = ~fclk;

   initial begin
      #50_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge fclk);
      #1;
   endtask

   task automatic pulse_end(input logic [7:0] data);
      wait_end  = 1'b1;
      wait_read = data;
      tick();
      wait_end  = 1'b0;
   endtask

   task automatic request(input logic glu, input logic com, input logic rnw,
                          input logic [7:0] data);
      iorq_n  = 1'b0;
      req_glu = glu;
      req_com = com;
      req_rnw = rnw;
      zd_in   = data;
      tick();
      req_glu = 1'b0;
      req_com = 1'b0;
      zd_in   = 8'h00;
   endtask

   task automatic end_io();
      iorq_n = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      n_checks++; if (zs.wait_n !== 1'b1) begin n_errors++; $display("FAIL rst_wait_n: got %b expected 1", zs.wait_n); end
      n_checks++; if (zs.zd_oe !== 1'b0) begin n_errors++; $display("FAIL rst_zd_oe: got %b expected 0", zs.zd_oe); end
      n_checks++; if (zs.zd_out !== 8'hFF) begin n_errors++; $display("FAIL rst_zd_out: got %h expected ff", zs.zd_out); end
      n_checks++; if (wait_write_s !== 8'h00) begin n_errors++; $display("FAIL rst_wait_write: got %h expected 00", wait_write_s); end
      n_checks++; if (wait_rnw_s !== 1'b1) begin n_errors++; $display("FAIL rst_wait_rnw: got %b expected 1", wait_rnw_s); end
      n_checks++; if (gaddr_s !== 8'h00) begin n_errors++; $display("FAIL rst_gaddr: got %h expected 00", gaddr_s); end
      n_checks++; if (status_s !== 3'b000) begin n_errors++; $display("FAIL rst_status: got %b expected 000", status_s); end
      n_checks++; if (tflag_s !== 1'b0) begin n_errors++; $display("FAIL rst_tflag: got %b expected 0", tflag_s); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_glu_write();
      sb_q.push_back('{zd_out: 8'hFF, zd_oe: 1'b0, tflag: 1'b0});
      request(1'b1, 1'b0, 1'b0, 8'h5A);
      n_checks++; if (zl.wait_n !== 1'b0) begin n_errors++; $display("FAIL glu_wait_n: got %b expected 0", zl.wait_n); end
      n_checks++; if (wait_write_l !== 8'h5A) begin n_errors++; $display("FAIL glu_wait_write: got %h expected 5a", wait_write_l); end
      n_checks++; if (status_l !== 3'b001) begin n_errors++; $display("FAIL glu_status: got %b expected 001", status_l); end
      repeat (99) tick();
      n_checks++; if (zl.wait_n !== 1'b0) begin n_errors++; $display("FAIL glu_still_wait: got %b expected 0", zl.wait_n); end
      pulse_end(8'hA5);
      n_checks++; if (zl.wait_n !== 1'b1) begin n_errors++; $display("FAIL glu_release: got %b expected 1", zl.wait_n); end
      n_checks++;
      if (sb_q.size() == 0) begin n_errors++; $display("FAIL glu_sb: got empty queue expected entry"); end
      else begin
         e = sb_q.pop_front();
         if ({zl.zd_out, zl.zd_oe, tflag_l} !== {e.zd_out, e.zd_oe, e.tflag}) begin
            n_errors++;
            $display("FAIL glu_result: got out=%h oe=%b tf=%b expected out=%h oe=%b tf=%b",
                     zl.zd_out, zl.zd_oe, tflag_l, e.zd_out, e.zd_oe, e.tflag);
         end
      end
      end_io();
   endtask

   task automatic test_com_read();
      sb_q.push_back('{zd_out: 8'hC3, zd_oe: 1'b1, tflag: 1'b0});
      request(1'b0, 1'b1, 1'b1, 8'h00);
      n_checks++; if (status_s !== 3'b111) begin n_errors++; $display("FAIL com_status: got %b expected 111", status_s); end
      repeat (5) tick();
      pulse_end(8'hC3);
      n_checks++; if (zs.wait_n !== 1'b1) begin n_errors++; $display("FAIL com_release: got %b expected 1", zs.wait_n); end
      n_checks++; if (status_s !== 3'b110) begin n_errors++; $display("FAIL com_status_done: got %b expected 110", status_s); end
      n_checks++;
      if (sb_q.size() == 0) begin n_errors++; $display("FAIL com_sb: got empty queue expected entry"); end
      else begin
         e = sb_q.pop_front();
         if ({zs.zd_out, zs.zd_oe, tflag_s} !== {e.zd_out, e.zd_oe, e.tflag}) begin
            n_errors++;
            $display("FAIL com_result: got out=%h oe=%b tf=%b expected out=%h oe=%b tf=%b",
                     zs.zd_out, zs.zd_oe, tflag_s, e.zd_out, e.zd_oe, e.tflag);
         end
      end
      repeat (3) tick();
      n_checks++; if ({zs.zd_out, zs.zd_oe} !== {8'hC3, 1'b1}) begin n_errors++; $display("FAIL com_hold: got out=%h oe=%b expected out=c3 oe=1", zs.zd_out, zs.zd_oe); end
      iorq_n = 1'b1;
      tick();
      n_checks++; if (zs.zd_oe !== 1'b0) begin n_errors++; $display("FAIL com_oe_off: got %b expected 0", zs.zd_oe); end
      tick();
   endtask

   task automatic test_timeout();
      int cyc;
      sb_q.push_back('{zd_out: 8'hFF, zd_oe: 1'b1, tflag: 1'b1});
      request(1'b1, 1'b0, 1'b1, 8'h00);
      cyc = 0;
      while (cyc < 40 && zs.wait_n === 1'b0) begin
         tick();
         cyc++;
      end
      n_checks++; if (cyc != 16) begin n_errors++; $display("FAIL to_cycles: got %0d expected 16", cyc); end
      n_checks++;
      if (sb_q.size() == 0) begin n_errors++; $display("FAIL to_sb: got empty queue expected entry"); end
      else begin
         e = sb_q.pop_front();
         if ({zs.zd_out, zs.zd_oe, tflag_s} !== {e.zd_out, e.zd_oe, e.tflag}) begin
            n_errors++;
            $display("FAIL to_result: got out=%h oe=%b tf=%b expected out=%h oe=%b tf=%b",
                     zs.zd_out, zs.zd_oe, tflag_s, e.zd_out, e.zd_oe, e.tflag);
         end
      end
      // Releases the long-timeout instance; the short one is in HOLD and ignores it.
      pulse_end(8'h99);
      n_checks++; if ({zs.zd_out, tflag_s} !== {8'hFF, 1'b1}) begin n_errors++; $display("FAIL to_hold_ignore: got out=%h tf=%b expected out=ff tf=1", zs.zd_out, tflag_s); end
      end_io();
      sb_q.push_back('{zd_out: 8'hFF, zd_oe: 1'b0, tflag: 1'b0});
      request(1'b1, 1'b0, 1'b0, 8'h42);
      n_checks++; if (tflag_s !== 1'b0) begin n_errors++; $display("FAIL to_flag_clear: got %b expected 0", tflag_s); end
      tick();
      pulse_end(8'h00);
      n_checks++;
      if (sb_q.size() == 0) begin n_errors++; $display("FAIL to2_sb: got empty queue expected entry"); end
      else begin
         e = sb_q.pop_front();
         if ({zs.wait_n, zs.zd_out, zs.zd_oe, tflag_s} !== {1'b1, e.zd_out, e.zd_oe, e.tflag}) begin
            n_errors++;
            $display("FAIL to2_result: got wn=%b out=%h oe=%b tf=%b expected wn=1 out=%h oe=%b tf=%b",
                     zs.wait_n, zs.zd_out, zs.zd_oe, tflag_s, e.zd_out, e.zd_oe, e.tflag);
         end
      end
      end_io();
   endtask

   task automatic test_simultaneous_req();
      sb_q.push_back('{zd_out: 8'hFF, zd_oe: 1'b0, tflag: 1'b0});
      request(1'b1, 1'b1, 1'b0, 8'h66);
      n_checks++; if (status_s !== 3'b001) begin n_errors++; $display("FAIL tie_status: got %b expected 001", status_s); end
      n_checks++; if (wait_write_s !== 8'h66) begin n_errors++; $display("FAIL tie_wait_write: got %h expected 66", wait_write_s); end
      repeat (2) tick();
      pulse_end(8'h00);
      n_checks++;
      if (sb_q.size() == 0) begin n_errors++; $display("FAIL tie_sb: got empty queue expected entry"); end
      else begin
         e = sb_q.pop_front();
         if ({zs.wait_n, zs.zd_out, zs.zd_oe, tflag_s} !== {1'b1, e.zd_out, e.zd_oe, e.tflag}) begin
            n_errors++;
            $display("FAIL tie_result: got wn=%b out=%h oe=%b tf=%b expected wn=1 out=%h oe=%b tf=%b",
                     zs.wait_n, zs.zd_out, zs.zd_oe, tflag_s, e.zd_out, e.zd_oe, e.tflag);
         end
      end
      end_io();
   endtask

   task automatic test_end_on_timeout();
      sb_q.push_back('{zd_out: 8'h3C, zd_oe: 1'b1, tflag: 1'b0});
      request(1'b1, 1'b0, 1'b1, 8'h00);
      repeat (15) tick();
      n_checks++; if (zs.wait_n !== 1'b0) begin n_errors++; $display("FAIL eot_pre: got %b expected 0", zs.wait_n); end
      pulse_end(8'h3C);
      n_checks++;
      if (sb_q.size() == 0) begin n_errors++; $display("FAIL eot_sb: got empty queue expected entry"); end
      else begin
         e = sb_q.pop_front();
         if ({zs.wait_n, zs.zd_out, zs.zd_oe, tflag_s} !== {1'b1, e.zd_out, e.zd_oe, e.tflag}) begin
            n_errors++;
            $display("FAIL eot_result: got wn=%b out=%h oe=%b tf=%b expected wn=1 out=%h oe=%b tf=%b",
                     zs.wait_n, zs.zd_out, zs.zd_oe, tflag_s, e.zd_out, e.zd_oe, e.tflag);
         end
      end
      end_io();
   endtask

   task automatic test_back_to_back();
      sb_q.push_back('{zd_out: 8'hFF, zd_oe: 1'b0, tflag: 1'b0});
      request(1'b1, 1'b0, 1'b0, 8'h11);
      tick();
      req_glu = 1'b1;
      req_rnw = 1'b1;
      zd_in   = 8'h22;
      tick();
      req_glu = 1'b0;
      n_checks++; if (wait_write_s !== 8'h11) begin n_errors++; $display("FAIL b2b_wait_write: got %h expected 11", wait_write_s); end
      n_checks++; if ({wait_rnw_s, status_s} !== {1'b0, 3'b001}) begin n_errors++; $display("FAIL b2b_dir: got rnw=%b st=%b expected rnw=0 st=001", wait_rnw_s, status_s); end
      pulse_end(8'h00);
      n_checks++;
      if (sb_q.size() == 0) begin n_errors++; $display("FAIL b2b_sb: got empty queue expected entry"); end
      else begin
         e = sb_q.pop_front();
         if ({zs.wait_n, zs.zd_out, zs.zd_oe, tflag_s} !== {1'b1, e.zd_out, e.zd_oe, e.tflag}) begin
            n_errors++;
            $display("FAIL b2b_result: got wn=%b out=%h oe=%b tf=%b expected wn=1 out=%h oe=%b tf=%b",
                     zs.wait_n, zs.zd_out, zs.zd_oe, tflag_s, e.zd_out, e.zd_oe, e.tflag);
         end
      end
      end_io();
   endtask

   task automatic test_reset_mid_wait();
      request(1'b1, 1'b0, 1'b1, 8'h55);
      repeat (3) tick();
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (zs.wait_n !== 1'b1) begin n_errors++; $display("FAIL rmw_async: got %b expected 1", zs.wait_n); end
      n_checks++;
      if ({zs.zd_oe, zs.zd_out, wait_write_s, wait_rnw_s, status_s, tflag_s} !== {1'b0, 8'hFF, 8'h00, 1'b1, 3'b000, 1'b0}) begin
         n_errors++;
         $display("FAIL rmw_outputs: got oe=%b out=%h ww=%h rnw=%b st=%b tf=%b expected oe=0 out=ff ww=00 rnw=1 st=000 tf=0",
                  zs.zd_oe, zs.zd_out, wait_write_s, wait_rnw_s, status_s, tflag_s);
      end
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      pulse_end(8'hEE);
      n_checks++;
      if ({zs.wait_n, zs.zd_oe, zs.zd_out, status_s} !== {1'b1, 1'b0, 8'hFF, 3'b000}) begin
         n_errors++;
         $display("FAIL rmw_end_ignored: got wn=%b oe=%b out=%h st=%b expected wn=1 oe=0 out=ff st=000",
                  zs.wait_n, zs.zd_oe, zs.zd_out, status_s);
      end
      end_io();
   endtask

   task automatic test_addr_port();
      addr_we = 1'b1;
      zd_in   = 8'h0B;
      tick();
      addr_we = 1'b0;
      n_checks++; if (gaddr_s !== 8'h0B) begin n_errors++; $display("FAIL addr_idle: got %h expected 0b", gaddr_s); end
      sb_q.push_back('{zd_out: 8'h77, zd_oe: 1'b1, tflag: 1'b0});
      request(1'b1, 1'b0, 1'b1, 8'h5E);
      tick();
      addr_we = 1'b1;
      zd_in   = 8'h0C;
      tick();
      addr_we = 1'b0;
      n_checks++; if (gaddr_s !== 8'h0C) begin n_errors++; $display("FAIL addr_wait: got %h expected 0c", gaddr_s); end
      n_checks++;
      if ({zs.wait_n, wait_write_s, status_s} !== {1'b0, 8'h5E, 3'b101}) begin
         n_errors++;
         $display("FAIL addr_wait_state: got wn=%b ww=%h st=%b expected wn=0 ww=5e st=101", zs.wait_n, wait_write_s, status_s);
      end
      pulse_end(8'h77);
      n_checks++;
      if (sb_q.size() == 0) begin n_errors++; $display("FAIL addr_sb: got empty queue expected entry"); end
      else begin
         e = sb_q.pop_front();
         if ({zs.wait_n, zs.zd_out, zs.zd_oe, tflag_s} !== {1'b1, e.zd_out, e.zd_oe, e.tflag}) begin
            n_errors++;
            $display("FAIL addr_result: got wn=%b out=%h oe=%b tf=%b expected wn=1 out=%h oe=%b tf=%b",
                     zs.wait_n, zs.zd_out, zs.zd_oe, tflag_s, e.zd_out, e.zd_oe, e.tflag);
         end
      end
      end_io();
   endtask

   initial begin
      rst_n     = 1'b0;
      iorq_n    = 1'b1;
      req_glu   = 1'b0;
      req_com   = 1'b0;
      req_rnw   = 1'b0;
      addr_we   = 1'b0;
      wait_end  = 1'b0;
      zd_in     = 8'h00;
      wait_read = 8'h00;

      test_reset();
      test_glu_write();
      test_com_read();
      test_timeout();
      test_simultaneous_req();
      test_end_on_timeout();
      test_back_to_back();
      test_reset_mid_wait();
      test_addr_port();

      n_checks++;
      if (sb_q.size() != 0) begin n_errors++; $display("FAIL sb_drain: got %0d entries expected 0", sb_q.size()); end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/zwait_ctrl.md
Name: zwait_ctrl

Overview:
- Z80-side counterpart of the AVR SPI slave.
- Stalls Z80 I/O accesses that the AVR services (gluclock/NVRAM data port, COM port) by holding /WAIT low.
- Latches write data and direction, and flags the pending request in the AVR status byte.
- Releases the Z80 on the slave's wait_end pulse and drives read data from wait_read back onto the Z80 bus; a timeout guards against a silent AVR.

Parameters:
- TIMEOUT, 24'd7_000_000: fclk cycles in WAIT before forced release (~0.25 s at 28 MHz); 0 disables timeout.
- IDLE_DATA, 8'hFF: read data returned on timeout.

Ports:
- fclk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- iorq_n  in  1  Z80 /IORQ, already synchronized to fclk
- req_glu  in  1  one-cycle pulse: decoder detected access to gluclock data port
- req_com  in  1  one-cycle pulse: decoder detected access to COM port
- req_rnw  in  1  direction of the access that caused the pulse, 1 = read
- addr_we  in  1  one-cycle pulse: Z80 write to gluclock address port (no wait)
- zd_in  in  8  Z80 data bus, write direction
- wait_read  in  8  data from AVR, valid when wait_end pulses
- wait_end  in  1  one-cycle pulse from SPI slave: AVR finished the transaction
- wait_n  out  1  Z80 /WAIT, 0 = stall
- wait_write  out  8  latched Z80 write data, to SPI slave
- wait_rnw  out  1  latched direction, to SPI slave
- gluclock_addr  out  8  gluclock register address, to SPI slave
- zd_out  out  8  read data to Z80 bus mux
- zd_oe  out  1  1 = drive zd_out onto Z80 bus
- status_out  out  3  to SPI status byte: [0] wait pending, [1] source (0 = glu, 1 = com), [2] rnw
- timeout_flag  out  1  sticky; set on forced release; cleared by next accepted request

Behaviour:
- Reset (async, rst_n = 0):
  - wait_n = 1, zd_oe = 0, zd_out = 8'hFF.
  - wait_write = 0, wait_rnw = 1, gluclock_addr = 0.
  - status_out = 0, timeout_flag = 0, state = IDLE, counter = 0.
  - Asserting reset mid-WAIT releases the Z80 immediately.
- gluclock_addr: loads zd_in on the cycle after addr_we, in any state.
- States: IDLE, WAIT, HOLD.
- IDLE:
  - req_glu or req_com moves to WAIT on the next edge. Both in the same cycle means glu wins; the com request is dropped.
  - On entry:
    - wait_n = 0.
    - wait_rnw = req_rnw; wait_write = zd_in (captured even for reads).
    - status_out = {req_rnw, src, 1}; counter cleared; timeout_flag cleared.
- WAIT:
  - wait_n held 0; counter increments each cycle.
  - Further requests are ignored. A concurrent addr_we is still honoured.
  - wait_end moves to HOLD:
    - zd_out = wait_read if wait_rnw = 1, else 8'hFF.
    - zd_oe = wait_rnw.
    - wait_n = 1; status_out[0] = 0.
  - Timeout: TIMEOUT ≠ 0 and counter = TIMEOUT-1 with no wait_end moves to HOLD:
    - zd_out = IDLE_DATA; zd_oe = wait_rnw.
    - timeout_flag = 1; wait_n = 1.
  - wait_end in the same cycle as the timeout is treated as a normal wait_end; timeout_flag is not set.
- HOLD:
  - wait_n = 1; zd_oe and zd_out stay stable while iorq_n = 0.
  - On iorq_n = 1, go to IDLE; zd_oe = 0 on that edge.
  - Requests arriving in HOLD are ignored.
- wait_end in IDLE or HOLD is ignored.
- Latency:
  - request pulse to wait_n = 0: 1 fclk.
  - wait_end to wait_n = 1: 1 fclk.
- Counter: 24 bits, saturates; never wraps.

Test Plan:
- Write to glu: req_glu = 1, req_rnw = 0, zd_in = 8'h5A.
  - Next cycle: wait_n = 0, wait_write = 8'h5A, status_out = 3'b001.
  - wait_end after 100 cycles: wait_n = 1 next cycle, zd_oe = 0.
- Read from com: req_com = 1, req_rnw = 1; wait_end with wait_read = 8'hC3.
  - status_out = 3'b111 during WAIT.
  - zd_out = 8'hC3 with zd_oe = 1 until iorq_n rises; zd_oe = 0 one cycle after.
- Timeout with TIMEOUT = 16, read, no wait_end:
  - wait_n low exactly 16 cycles.
  - zd_out = 8'hFF, timeout_flag = 1.
  - Next request clears timeout_flag.
- Simultaneous events, each as a separate case:
  - req_glu and req_com together: status_out[1] = 0.
  - wait_end on the timeout cycle: zd_out = wait_read, timeout_flag = 0.
  - Second req_glu during WAIT: wait_write unchanged.
- Reset mid-WAIT: rst_n low for 3 cycles during WAIT.
  - wait_n = 1 asynchronously; all outputs at reset values.
  - wait_end after reset is ignored.
- Address port: addr_we with zd_in = 8'h0B in IDLE, then again during WAIT with 8'h0C.
  - gluclock_addr = 8'h0B, then 8'h0C.
  - WAIT state unaffected.
